encoder_8_3_seq: RTL and testbench

// - Sequential 8-to-3 encoder: inverse of the team's 3-to-8 decoder. Captures a multi-hot
//   8-bit request vector and emits the 3-bit index of each set bit, one per valid/ready

---
 rtl/enc_pkg.sv | 26 ++
 rtl/prio_enc_8_3.sv | 35 +++
 rtl/encoder_8_3_seq.sv | 135 +++++++++++++
 tb/tb_encoder_8_3_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder.
// Contents:
//   - WIDTH / IDX_W  : default request-vector and index widths
//   - state_t        : FSM state encoding (IDLE, EMIT)
//   - popcount()     : number of set bits in a vector (up to 64 bits wide)
package enc_pkg;

  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Callers zero-extend their vector to 64 bits, so one function serves any WIDTH.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational priority encoder.
// Ports:
//   vec  in   WIDTH   request vector
//   idx  out  IDX_W   index of the winning set bit (0 when vec == 0)
//   any  out  1       at least one bit of vec is set
// PRIORITY_HIGH = 0 selects the lowest set index, 1 selects the highest.
module prio_enc_8_3
  import enc_pkg::*;
#(
  parameter int WIDTH         = enc_pkg::WIDTH,
  parameter int IDX_W         = $clog2(WIDTH),
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan so that the preferred bit is visited last and overwrites earlier hits.
  always_comb begin
    idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 encoder.
// Captures a multi-hot request vector and emits the index of each set bit, one per
// valid/ready handshake, in priority order.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   En         in   1        enable; 0 freezes all state and forces valid/done low
//   load       in   1        capture I (accepted only in IDLE)
//   I          in   WIDTH    multi-hot request vector
//   Y          out  IDX_W    index currently offered
//   valid      out  1        Y awaits acceptance
//   ready      in   1        consumer accepts Y on valid & ready at a rising edge
//   busy       out  1        FSM is in EMIT
//   done       out  1        one-cycle pulse once a captured vector is drained
//   remain     out  IDX_W+1  set bits still pending, including the one on Y
//   dbg_state  out  state_t  FSM state for observation
// Handshake: a transfer happens at a rising edge where valid, ready and En are all 1.
// Y, pend and remain are stable while valid=1 and no transfer occurs.
module encoder_8_3_seq
  import enc_pkg::*;
#(
  parameter int WIDTH         = enc_pkg::WIDTH,
  parameter bit PRIORITY_HIGH = 1'b0,
  localparam int IDX_W        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             load,
  input  logic [WIDTH-1:0] I,
  output logic [IDX_W-1:0] Y,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   remain,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [IDX_W:0]   remain_q, remain_d;

  // Vector the encoder looks at: the freshly loaded I in IDLE, or the pending
  // set with the currently offered bit removed in EMIT. Y is registered, so the
  // encoder must see what pend will hold after this edge.
  logic [WIDTH-1:0] cand;
  logic [IDX_W-1:0] cand_idx;
  logic             cand_any;

  assign cand = (state_q == IDLE) ? I : (pend_q & ~(WIDTH'(1) << y_q));

  prio_enc_8_3 #(
    .WIDTH        (WIDTH),
    .IDX_W        (IDX_W),
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) u_prio (
    .vec(cand),
    .idx(cand_idx),
    .any(cand_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    y_d      = y_q;
    valid_d  = valid_q;
    done_d   = done_q;
    remain_d = remain_q;
    // With En low everything holds, which also keeps a pending done pulse
    // parked until the first enabled edge.
    if (En) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            pend_d   = I;
            remain_d = (IDX_W + 1)'(popcount(64'(I)));
            if (cand_any) begin
              state_d = EMIT;
              valid_d = 1'b1;
              y_d     = cand_idx;
            end else begin
              done_d  = 1'b1;
            end
          end
        end
        EMIT: begin
          // load is not examined here, so a load on the final handshake is dropped.
          if (valid_q && ready) begin
            pend_d   = cand;
            remain_d = remain_q - 1'b1;
            if (cand_any) begin
              y_d = cand_idx;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Y         = y_q;
  assign valid     = valid_q & En;
  assign done      = done_q & En;
  assign busy      = (state_q == EMIT);
  assign remain    = remain_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Directed bench for encoder_8_3_seq: a low-priority instance and a high-priority
// instance share all inputs; each section checks the instance it targets.
module tb_encoder_8_3_seq;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] i_vec = 8'h00;

  logic [2:0] y0, y1;
  logic       valid0, valid1, busy0, busy1, done0, done1;
  logic [3:0] remain0, remain1;
  state_t     st0, st1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  encoder_8_3_seq #(.WIDTH(8), .PRIORITY_HIGH(1'b0)) u_lo (
    .clk(clk), .rst(rst), .En(en), .load(load), .I(i_vec),
    .Y(y0), .valid(valid0), .ready(ready), .busy(busy0), .done(done0),
    .remain(remain0), .dbg_state(st0)
  );

  encoder_8_3_seq #(.WIDTH(8), .PRIORITY_HIGH(1'b1)) u_hi (
    .clk(clk), .rst(rst), .En(en), .load(load), .I(i_vec),
    .Y(y1), .valid(valid1), .ready(ready), .busy(busy1), .done(done1),
    .remain(remain1), .dbg_state(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks all low-priority outputs at once.
  task automatic chk_lo(input string tag, input logic v, input logic [2:0] y,
                        input logic [3:0] rem, input logic b, input logic d);
    chk({tag, ".valid"}, 32'(valid0), 32'(v));
    if (v) chk({tag, ".Y"}, 32'(y0), 32'(y));
    chk({tag, ".remain"}, 32'(remain0), 32'(rem));
    chk({tag, ".busy"}, 32'(busy0), 32'(b));
    chk({tag, ".done"}, 32'(done0), 32'(d));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst.Y", 32'(y0), 32'h0);
    chk_lo("rst", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
    chk("rst.state", 32'(st0), 32'(IDLE));

    // A: 1010_0100 with ready=1 -> 2,5,7 then done
    i_vec = 8'b1010_0100; load = 1'b1; ready = 1'b1;
    step(); load = 1'b0; i_vec = 8'h00;
    chk_lo("a1", 1'b1, 3'd2, 4'd3, 1'b1, 1'b0);
    chk("a1.state", 32'(st0), 32'(EMIT));
    step(); chk_lo("a2", 1'b1, 3'd5, 4'd2, 1'b1, 1'b0);
    step(); chk_lo("a3", 1'b1, 3'd7, 4'd1, 1'b1, 1'b0);
    step(); chk_lo("a4", 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    chk("a4.Yhold", 32'(y0), 32'd7);
    step(); chk_lo("a5", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

    // B: backpressure, load while busy and on the last handshake is ignored
    i_vec = 8'b1010_0100; load = 1'b1; ready = 1'b0;
    step(); load = 1'b0;
    chk_lo("b1", 1'b1, 3'd2, 4'd3, 1'b1, 1'b0);
    i_vec = 8'hFF; load = 1'b1;
    step(); chk_lo("b2", 1'b1, 3'd2, 4'd3, 1'b1, 1'b0);
    load = 1'b0;
    step(); chk_lo("b3", 1'b1, 3'd2, 4'd3, 1'b1, 1'b0);
    ready = 1'b1;
    step(); chk_lo("b4", 1'b1, 3'd5, 4'd2, 1'b1, 1'b0);
    step(); chk_lo("b5", 1'b1, 3'd7, 4'd1, 1'b1, 1'b0);
    load = 1'b1; i_vec = 8'hFF;
    step(); chk_lo("b6", 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    load = 1'b0; i_vec = 8'h00;
    step(); chk_lo("b7", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

    // C: empty vector -> done only; load during done cycle accepted; 0xFF drains 0..7
    load = 1'b1; i_vec = 8'h00;
    step(); chk_lo("c1", 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    i_vec = 8'hFF;
    step(); load = 1'b0; i_vec = 8'h00;
    chk_lo("c2", 1'b1, 3'd0, 4'd8, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk_lo($sformatf("c_ff%0d", k), 1'b1, 3'(k), 4'(8 - k), 1'b1, 1'b0);
    end
    step(); chk_lo("c_end", 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    step(); chk_lo("c_post", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

    // D: En=0 mid-stream, then done deferral through En=0
    load = 1'b1; i_vec = 8'b1010_0100; ready = 1'b1;
    step(); load = 1'b0;
    chk_lo("d1", 1'b1, 3'd2, 4'd3, 1'b1, 1'b0);
    step(); chk_lo("d2", 1'b1, 3'd5, 4'd2, 1'b1, 1'b0);
    en = 1'b0; #1;
    chk("d_en0.valid", 32'(valid0), 32'h0);
    for (int k = 0; k < 3; k++) begin
      load = (k == 1); i_vec = 8'hFF;
      step();
      chk_lo($sformatf("d_hold%0d", k), 1'b0, 3'd0, 4'd2, 1'b1, 1'b0);
      chk($sformatf("d_hold%0d.Y", k), 32'(y0), 32'd5);
    end
    load = 1'b0; i_vec = 8'h00;
    en = 1'b1; #1;
    chk("d_resume.valid", 32'(valid0), 32'h1);
    chk("d_resume.Y", 32'(y0), 32'd5);
    step(); chk_lo("d3", 1'b1, 3'd7, 4'd1, 1'b1, 1'b0);
    step(); chk_lo("d4", 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
    en = 1'b0; #1;
    chk("d_defer0.done", 32'(done0), 32'h0);
    step(); chk("d_defer1.done", 32'(done0), 32'h0);
    en = 1'b1; #1;
    chk("d_defer2.done", 32'(done0), 32'h1);
    step(); chk("d_defer3.done", 32'(done0), 32'h0);

    // Reset mid-stream: no done pulse, everything cleared
    load = 1'b1; i_vec = 8'b1010_0100; ready = 1'b1;
    step(); load = 1'b0;
    step(); chk_lo("r1", 1'b1, 3'd5, 4'd2, 1'b1, 1'b0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_lo("r2", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
    chk("r2.Y", 32'(y0), 32'h0);
    step(); chk_lo("r3", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);

    // High priority instance: 0001_0011 -> 4,1,0
    load = 1'b1; i_vec = 8'b0001_0011; ready = 1'b1;
    step(); load = 1'b0; i_vec = 8'h00;
    chk("h1.Y", 32'(y1), 32'd4); chk("h1.valid", 32'(valid1), 32'h1);
    chk("h1.remain", 32'(remain1), 32'd3);
    step(); chk("h2.Y", 32'(y1), 32'd1); chk("h2.remain", 32'(remain1), 32'd2);
    step(); chk("h3.Y", 32'(y1), 32'd0); chk("h3.remain", 32'(remain1), 32'd1);
    step(); chk("h4.done", 32'(done1), 32'h1); chk("h4.valid", 32'(valid1), 32'h0);
    chk("h4.busy", 32'(busy1), 32'h0);
    step(); chk("h5.done", 32'(done1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
